// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ccff_loader_pkg: state encoding and per-tile chain lengths for ccff_loader  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BYTE_W             = 8;
    localparam int CHAIN_LEN_SB_1__0_ = 28;

endpackage : ccff_loader_pkg
`default_nettype wire

// File: rtl/ccff_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ccff_loader: serialises configuration bytes LSB first into a CCFF chain     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_SB_1__0_
) (
    input  logic                           prog_clk,
    input  logic                           pReset,
    input  logic                           start,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           ccff_head,
    input  logic                           ccff_tail,
    output logic                           shift_en,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic                           tail_parity,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    // Remaining-bit arithmetic must be wide enough to represent a full byte.
    localparam int REM_W = (CNT_W > 4) ? CNT_W : 4;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CHAIN_LEN);
    localparam logic [REM_W-1:0] CHAIN_REM = REM_W'(CHAIN_LEN);
    localparam logic [REM_W-1:0] BYTE_REM  = REM_W'(BYTE_W);

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bits_left_q, bits_left_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             tail_parity_q, tail_parity_d;
    logic             err_q, err_d;
    logic [REM_W-1:0] remaining;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bits_left_q   <= '0;
            bit_cnt_q     <= '0;
            tail_parity_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bits_left_q   <= bits_left_d;
            bit_cnt_q     <= bit_cnt_d;
            tail_parity_q <= tail_parity_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bits_left_d   = bits_left_q;
        bit_cnt_d     = bit_cnt_q;
        tail_parity_d = tail_parity_q;
        err_d         = err_q;
        in_ready      = 1'b0;
        shift_en      = 1'b0;
        ccff_head     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        remaining     = CHAIN_REM - REM_W'(bit_cnt_q);

        if (start && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d       = ST_FETCH;
                    bit_cnt_d     = '0;
                    tail_parity_d = 1'b0;
                    err_d         = 1'b0;
                end
            end
            ST_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d     = in_data;
                    // Final partial byte: only the bits still owed to the chain are shifted.
                    bits_left_d = (remaining < BYTE_REM) ? remaining[3:0] : 4'd8;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en      = 1'b1;
                ccff_head     = shreg_q[0];
                shreg_d       = {1'b0, shreg_q[7:1]};
                bit_cnt_d     = bit_cnt_q + 1'b1;
                bits_left_d   = bits_left_q - 4'd1;
                tail_parity_d = tail_parity_q ^ ccff_tail;
                if (bit_cnt_q == (LAST_CNT - 1'b1)) begin
                    state_d = ST_DONE;
                end else if (bits_left_q == 4'd1) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err         = err_q;
    assign tail_parity = tail_parity_q;
    assign bit_cnt     = bit_cnt_q;

endmodule : ccff_loader
`default_nettype wire
